serial_adder: RTL



---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_adder.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding and
// the sizing helper for the bit counter.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter is one bit wider than log2(width), so WIDTH-1 always fits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: sum = a + b + carry_in over WIDTH shift cycles.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  import serial_arith_pkg::*;

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             carry;
  logic             fa_s, fa_c;
  logic             last;
  logic             capture;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign capture = start && ((state == IDLE) || (state == DONE));
  assign sum     = sum_r;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last)  next_state = DONE;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Result bits enter at the MSB so the sum is right-aligned after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_r     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      carry_out <= 1'b0;
    end else if (capture) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= carry_in;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      sum_r <= {fa_s, sum_r[WIDTH-1:1]};
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_c;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) carry_out <= fa_c;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // On the final edge the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow <= 1'b0;
    else if (state == SHIFT && last) overflow <= carry ^ fa_c;
  end
`endif

endmodule
